// File: rtl/reg_arbiter.sv
// Round-robin arbiter that shares the single register-mux port between several masters.
// One access is outstanding at a time. Commands are latched at grant, and an access that gets no downstream handshake is aborted.
module reg_arbiter #(
    parameter int  NUM_MSTRS = 2,
    parameter int  NUM_RGNS  = 4,
    parameter int  TIMEOUT   = 256,
    localparam int CHAN_W    = (NUM_RGNS > 1) ? $clog2(NUM_RGNS) : 1
) (
    input  logic                             sysClk_in,
    input  logic                             sysRstN_in,
    input  logic [NUM_MSTRS-1:0]             mstCmdValid_in,
    input  logic [NUM_MSTRS-1:0]             mstCmdWr_in,
    input  logic [NUM_MSTRS-1:0][CHAN_W-1:0] mstChan_in,
    input  logic [NUM_MSTRS-1:0][31:0]       mstWrData_in,
    output logic [NUM_MSTRS-1:0]             mstCmdReady_out,
    output logic [31:0]                      mstRdData_out,
    output logic [NUM_MSTRS-1:0]             mstRdValid_out,
    input  logic [NUM_MSTRS-1:0]             mstRdReady_in,
    output logic [CHAN_W-1:0]                cpuChan_out,
    output logic                             cpuWrValid_out,
    output logic [31:0]                      cpuWrData_out,
    input  logic                             cpuWrReady_in,
    input  logic [31:0]                      cpuRdData_in,
    input  logic                             cpuRdValid_in,
    output logic                             cpuRdReady_out,
    output logic                             busy_out,
    output logic                             timeout_out
);

    localparam int                IDX_W      = $clog2(NUM_MSTRS);
    localparam int                CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CHAN_W:0]   RGN_LIMIT  = (CHAN_W + 1)'(NUM_RGNS);
    localparam logic [IDX_W-1:0]  LAST_MSTR  = IDX_W'(NUM_MSTRS - 1);
    localparam logic [31:0]       ABORT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [IDX_W-1:0]       gnt_idx_r;
    logic [IDX_W-1:0]       arb_idx_s;
    logic [IDX_W-1:0]       cand_s;
    logic [IDX_W-1:0]       cur_idx_s;
    logic                   arb_found_s;
    logic                   chan_ok_s;
    logic                   expire_s;
    logic                   complete_s;
    logic                   abort_s;
    logic                   load_rd_s;
    logic [31:0]            load_data_s;
    logic [NUM_MSTRS-1:0]   cmd_ready_s;
    logic [NUM_MSTRS-1:0]   rd_valid_s;
    logic [CNT_W-1:0]       to_cnt_r;
    logic [CHAN_W-1:0]      chan_r;
    logic [31:0]            wr_data_r;
    logic [31:0]            rd_data_r;
    logic [NUM_MSTRS-1:0]   rd_valid_r;
    logic                   wr_valid_r;
    logic                   rd_ready_r;
    logic                   busy_r;
    logic                   timeout_r;

    // Round-robin search: first valid master at or after rr_ptr_r, wrapping.
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = rr_ptr_r;
        cand_s      = rr_ptr_r;
        for (int k = 0; k < NUM_MSTRS; k++) begin
            cand_s      = IDX_W'((int'(rr_ptr_r) + k) % NUM_MSTRS);
            arb_idx_s   = (!arb_found_s && mstCmdValid_in[cand_s]) ? cand_s : arb_idx_s;
            arb_found_s = arb_found_s | mstCmdValid_in[cand_s];
        end
    end

    // Out-of-range regions are never presented to the register mux.
    assign chan_ok_s = ({1'b0, mstChan_in[arb_idx_s]} < RGN_LIMIT);
    assign expire_s  = (TIMEOUT != 0) && (to_cnt_r == TO_LAST);
    assign cur_idx_s = (state_r == ST_IDLE) ? arb_idx_s : gnt_idx_r;

    // FSM state register.
    always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
        if (!sysRstN_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; a handshake in the expiry cycle takes priority over the abort.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_found_s) begin
                    if (mstCmdWr_in[arb_idx_s]) begin
                        state_s = chan_ok_s ? ST_WR : ST_IDLE;
                    end else begin
                        state_s = chan_ok_s ? ST_RD : ST_RSP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR:   state_s = (cpuWrReady_in || expire_s) ? ST_IDLE : ST_WR;
            ST_RD:   state_s = (cpuRdValid_in || expire_s) ? ST_RSP : ST_RD;
            ST_RSP:  state_s = mstRdReady_in[gnt_idx_r] ? ST_IDLE : ST_RSP;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output and event decode.
    always_comb begin
        cmd_ready_s = '0;
        rd_valid_s  = '0;
        complete_s  = 1'b0;
        abort_s     = 1'b0;
        load_rd_s   = 1'b0;
        load_data_s = ABORT_DATA;
        case (state_r)
            ST_IDLE: begin
                if (arb_found_s && sysRstN_in) begin
                    cmd_ready_s[arb_idx_s] = 1'b1;
                    abort_s    = !chan_ok_s;
                    complete_s = !chan_ok_s && mstCmdWr_in[arb_idx_s];
                    load_rd_s  = !chan_ok_s && !mstCmdWr_in[arb_idx_s];
                end else begin
                    cmd_ready_s = '0;
                end
            end
            ST_WR: begin
                complete_s = cpuWrReady_in || expire_s;
                abort_s    = !cpuWrReady_in && expire_s;
            end
            ST_RD: begin
                load_rd_s   = cpuRdValid_in || expire_s;
                abort_s     = !cpuRdValid_in && expire_s;
                load_data_s = cpuRdValid_in ? cpuRdData_in : ABORT_DATA;
            end
            ST_RSP:  complete_s = mstRdReady_in[gnt_idx_r];
            default: complete_s = 1'b0;
        endcase
        if (state_s == ST_RSP) begin
            rd_valid_s[cur_idx_s] = 1'b1;
        end else begin
            rd_valid_s = '0;
        end
    end

    // Datapath, round-robin pointer, timeout counter and registered outputs.
    always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
        if (!sysRstN_in) begin
            rr_ptr_r   <= '0;
            gnt_idx_r  <= '0;
            to_cnt_r   <= '0;
            chan_r     <= '0;
            wr_data_r  <= 32'h0000_0000;
            rd_data_r  <= 32'h0000_0000;
            rd_valid_r <= '0;
            wr_valid_r <= 1'b0;
            rd_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            to_cnt_r <= (((state_r == ST_WR) || (state_r == ST_RD)) && (state_s == state_r))
                        ? to_cnt_r + CNT_W'(1) : '0;
            if ((state_r == ST_IDLE) && arb_found_s) begin
                gnt_idx_r <= arb_idx_s;
            end
            if ((state_r == ST_IDLE) && arb_found_s && chan_ok_s) begin
                chan_r    <= mstChan_in[arb_idx_s];
                wr_data_r <= mstWrData_in[arb_idx_s];
            end
            if (load_rd_s) begin
                rd_data_r <= load_data_s;
            end
            if (complete_s) begin
                rr_ptr_r <= (cur_idx_s == LAST_MSTR) ? '0 : cur_idx_s + IDX_W'(1);
            end
            rd_valid_r <= rd_valid_s;
            wr_valid_r <= (state_s == ST_WR);
            rd_ready_r <= (state_s == ST_RD);
            busy_r     <= (state_s != ST_IDLE);
            timeout_r  <= abort_s;
        end
    end

    assign mstCmdReady_out = cmd_ready_s;
    assign mstRdData_out   = rd_data_r;
    assign mstRdValid_out  = rd_valid_r;
    assign cpuChan_out     = chan_r;
    assign cpuWrValid_out  = wr_valid_r;
    assign cpuWrData_out   = wr_data_r;
    assign cpuRdReady_out  = rd_ready_r;
    assign busy_out        = busy_r;
    assign timeout_out     = timeout_r;

endmodule
